// File: rtl/mldsa_top.sv
// ML-DSA accelerator front end: AHB-lite register slave, private-key
// buffer and command sequencer with an XOR digest sweep for SIGNING.
module mldsa_top #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 64,
  parameter int CMD_LATENCY    = 64,
  parameter int KEY_WORDS      = 1224
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hsel_i,
  input  logic                      hwrite_i,
  input  logic                      hready_i,
  input  logic [1:0]                htrans_i,
  input  logic [2:0]                hsize_i,
  output logic                      hresp_o,
  output logic                      hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o
);

  localparam int AW = AHB_ADDR_WIDTH;
  localparam int HW = AHB_DATA_WIDTH / 2;
  localparam int IW = $clog2(KEY_WORDS);
  localparam int CW = $clog2(CMD_LATENCY + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_ACC  = 2'd3;

  localparam logic [AW-1:0] A_NAME   = AW'('h00);
  localparam logic [AW-1:0] A_CTRL   = AW'('h10);
  localparam logic [AW-1:0] A_STATUS = AW'('h18);
  localparam logic [AW-1:0] A_DIGEST = AW'('h20);
  localparam logic [AW-1:0] A_KEY    = AW'('h4000);
  localparam logic [AW-1:0] KEY_SPAN = AW'(4 * KEY_WORDS);
  localparam logic [31:0]   NAME_VAL = 32'h4D4C4453;

  logic          dv_q, dv_d;
  logic          dw_q, dw_d;
  logic [AW-1:0] da_q, da_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          chain_q, chain_d;
  logic          valid_q, valid_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   digest_q, digest_d;
  logic [31:0]   key_rd_q;
  logic [31:0]   key_mem [KEY_WORDS];

  logic          wr_ctrl, wr_key, key_hit;
  logic [AW-1:0] key_off;
  logic [IW-1:0] key_idx;
  logic [31:0]   wdata, rdata;
  logic [2:0]    cmd;

  assign hresp_o     = 1'b0;
  assign hreadyout_o = 1'b1;

  always_comb begin
    dv_d = hsel_i & hready_i & htrans_i[1] & (hsize_i == 3'b010);
    dw_d = hwrite_i;
    da_d = haddr_i;
  end

  assign wdata   = da_q[2] ? hwdata_i[2*HW-1:HW] : hwdata_i[HW-1:0];
  assign cmd     = wdata[2:0];
  assign key_off = da_q - A_KEY;
  assign key_hit = (da_q >= A_KEY) && (key_off < KEY_SPAN);
  assign key_idx = key_off[IW+1:2];
  assign wr_ctrl = dv_q & dw_q & (da_q == A_CTRL);
  assign wr_key  = dv_q & dw_q & key_hit & (state_q == S_IDLE);

  // Key buffer is intentionally unreset; read port is registered.
  always_ff @(posedge clk) begin
    if (wr_key) key_mem[key_idx] <= wdata;
    key_rd_q <= key_mem[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    chain_d  = chain_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    digest_d = digest_q;
    if (wr_ctrl && wdata[3]) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      digest_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_ctrl) begin
            unique case (1'b1)
              (cmd == 3'd1) || (cmd == 3'd3),
              (cmd == 3'd4): begin
                state_d = S_BUSY;
                cnt_d   = '0;
                chain_d = (cmd == 3'd4);
                valid_d = 1'b0;
              end
              (cmd == 3'd2): begin
                state_d = S_RD;
                idx_d   = '0;
                acc_d   = '0;
                valid_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cnt_q == CW'(CMD_LATENCY - 1)) begin
            if (chain_q) begin
              state_d = S_RD;
              idx_d   = '0;
              acc_d   = '0;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RD: begin
          // key_rd_q lags idx_q by one, so word 0 lands on idx 1
          if (idx_q != '0) acc_d = acc_q ^ key_rd_q;
          if (idx_q == IW'(KEY_WORDS - 1)) state_d = S_ACC;
          else idx_d = idx_q + 1'b1;
        end
        default: begin
          digest_d = acc_q ^ key_rd_q;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dv_q     <= 1'b0;
      dw_q     <= 1'b0;
      da_q     <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      digest_q <= '0;
    end else begin
      dv_q     <= dv_d;
      dw_q     <= dw_d;
      da_q     <= da_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      digest_q <= digest_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (dv_q && !dw_q) begin
      unique case (1'b1)
        (da_q == A_NAME):   rdata = NAME_VAL;
        (da_q == A_STATUS): rdata = {30'd0, valid_q, state_q == S_IDLE};
        (da_q == A_DIGEST): rdata = digest_q;
        default:            rdata = '0;
      endcase
    end
  end

  assign hrdata_o = da_q[2] ? {rdata, {HW{1'b0}}} : {{HW{1'b0}}, rdata};

endmodule

// File: tb/tb_mldsa_top.sv
// Directed bench for mldsa_top: register map, command latencies,
// SIGNING digest, ignore rules, zeroize and mid-command reset.
module tb_mldsa_top;

  localparam logic [31:0] A_NAME   = 32'h00;
  localparam logic [31:0] A_CTRL   = 32'h10;
  localparam logic [31:0] A_STATUS = 32'h18;
  localparam logic [31:0] A_DIGEST = 32'h20;
  localparam logic [31:0] A_KEY    = 32'h4000;
  localparam int          LAT      = 64;
  localparam int          NKEY     = 1224;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] haddr;
  logic [63:0] hwdata;
  logic        hsel, hwrite, hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hresp, hreadyout;
  logic [63:0] hrdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] key [NKEY];
  logic [31:0] kx;
  logic [63:0] d;
  logic [31:0] st;
  int          n;

  always #5 clk = ~clk;

  mldsa_top dut (
    .clk(clk), .rst_b(rst_b),
    .haddr_i(haddr), .hwdata_i(hwdata),
    .hsel_i(hsel), .hwrite_i(hwrite),
    .hready_i(hready), .htrans_i(htrans),
    .hsize_i(hsize), .hresp_o(hresp),
    .hreadyout_o(hreadyout), .hrdata_o(hrdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      chk("hresp_hready", {62'd0, hresp, hreadyout}, 64'h1);
    end
  end

  // Leaves the bus parked on a STATUS read pipelined behind the write.
  task automatic wr(input logic [31:0] a, input logic [31:0] v,
                    input logic [2:0] sz);
    @(negedge clk);
    haddr = a; hwrite = 1'b1; hsel = 1'b1;
    htrans = 2'b10; hsize = sz;
    @(negedge clk);
    hwdata = a[2] ? {v, 32'h0} : {32'h0, v};
    haddr = A_STATUS; hwrite = 1'b0; hsize = 3'b010;
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz,
                    output logic [63:0] v);
    @(negedge clk);
    haddr = a; hwrite = 1'b0; hsel = 1'b1;
    htrans = 2'b10; hsize = sz;
    @(negedge clk);
    v = hrdata;
  endtask

  task automatic busy(output int cnt, output logic [31:0] s);
    cnt = 0;
    s = '0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      s = hrdata[31:0];
      if (s[0]) break;
      cnt++;
    end
  endtask

  initial begin
    rst_b = 1'b0; haddr = '0; hwdata = '0; hsel = 1'b0;
    hwrite = 1'b0; hready = 1'b1; htrans = 2'b00; hsize = 3'b010;
    repeat (3) @(negedge clk);
    chk("rst_hrdata", hrdata, 64'h0);
    chk("rst_hresp", {63'd0, hresp}, 64'h0);
    chk("rst_hreadyout", {63'd0, hreadyout}, 64'h1);
    rst_b = 1'b1;

    rd(A_NAME, 3'b010, d);   chk("name", d, 64'h4D4C4453);
    rd(A_STATUS, 3'b010, d); chk("rst_status", d, 64'h1);
    rd(A_DIGEST, 3'b010, d); chk("rst_digest", d, 64'h0);

    wr(A_CTRL, 32'd1, 3'b010);
    busy(n, st);
    chk("keygen_lat", 64'(n), 64'(LAT));
    chk("keygen_st", 64'(st), 64'h3);

    wr(A_CTRL, 32'd1, 3'b010);
    repeat (10) @(negedge clk);
    wr(A_CTRL, 32'd3, 3'b010);
    busy(n, st);
    chk("busy_ignore_lat", 64'(12 + n), 64'(LAT));
    chk("busy_ignore_st", 64'(st), 64'h3);

    kx = '0;
    for (int i = 0; i < NKEY; i++) begin
      key[i] = $urandom;
      kx ^= key[i];
      wr(A_KEY + 32'(4 * i), key[i], 3'b010);
    end
    rd(A_KEY, 3'b010, d);         chk("key_rd0", d, 64'h0);
    rd(A_KEY + 32'd4, 3'b010, d); chk("key_rd1", d, 64'h0);

    wr(A_CTRL, 32'd2, 3'b010);
    busy(n, st);
    chk("sign_lat", 64'(n), 64'(NKEY + 1));
    chk("sign_st", 64'(st), 64'h3);
    rd(A_DIGEST, 3'b010, d);
    chk("sign_digest", d, {32'h0, kx});

    wr(A_CTRL, 32'd2, 3'b010);
    repeat (100) @(negedge clk);
    wr(A_KEY, ~key[0], 3'b010);
    busy(n, st);
    chk("sign2_lat", 64'(102 + n), 64'(NKEY + 1));
    rd(A_DIGEST, 3'b010, d);
    chk("sign2_digest", d, {32'h0, kx});

    wr(A_CTRL, 32'd2, 3'b010);
    repeat (50) @(negedge clk);
    wr(A_CTRL, 32'h8, 3'b010);
    @(negedge clk);
    chk("zeroize_st", hrdata, 64'h1);
    rd(A_DIGEST, 3'b010, d);
    chk("zeroize_digest", d, 64'h0);

    wr(A_CTRL, 32'd1, 3'b010);
    busy(n, st);
    chk("keygen2_lat", 64'(n), 64'(LAT));
    wr(A_CTRL, 32'd0, 3'b010);
    @(negedge clk); chk("cmd0_ignored", hrdata, 64'h3);
    wr(A_CTRL, 32'd5, 3'b010);
    @(negedge clk); chk("cmd5_ignored", hrdata, 64'h3);
    wr(A_CTRL, 32'd7, 3'b010);
    @(negedge clk); chk("cmd7_ignored", hrdata, 64'h3);
    wr(A_CTRL, 32'd1, 3'b011);
    @(negedge clk); chk("hsize_wr_ignored", hrdata, 64'h3);
    rd(A_NAME, 3'b011, d);
    chk("hsize_rd_zero", d, 64'h0);

    wr(A_CTRL, 32'd4, 3'b010);
    busy(n, st);
    chk("kgsign_lat", 64'(n), 64'(LAT + NKEY + 1));
    chk("kgsign_st", 64'(st), 64'h3);
    rd(A_DIGEST, 3'b010, d);
    chk("kgsign_digest", d, {32'h0, kx});

    wr(A_CTRL, 32'd1, 3'b010);
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_hrdata", hrdata, 64'h0);
    rst_b = 1'b1;
    rd(A_STATUS, 3'b010, d); chk("midrst_status", d, 64'h1);
    rd(A_DIGEST, 3'b010, d); chk("midrst_digest", d, 64'h0);
    wr(A_CTRL, 32'd3, 3'b010);
    busy(n, st);
    chk("verify_lat", 64'(n), 64'(LAT));
    chk("verify_st", 64'(st), 64'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
